mag_req_scheduler: RTL and testbench
====================================

Name: mag_req_scheduler

Overview:
- Shares one iterative vector-magnitude datapath, floor(sqrt(x²+y²)), between two requesters.
- Round-robin arbitration; one request in flight at a time.
- Sequences the datapath through a square stage and a bit-serial root stage, then returns the result with the requester ID over a valid/ready response channel.
- Sits between the I/O pin-mux and the magnitude datapath in the top-level tile.

Parameters:
- DATA_W, 8: width of each x/y operand (unsigned).
- Derived (not overridable): SUM_W = 2*DATA_W+1; ROOT_W = DATA_W+1; ITER = DATA_W+1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_x  input  2*DATA_W  packed x operands; requester i uses [i*DATA_W +: DATA_W].
- req_y  input  2*DATA_W  packed y operands, same packing.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that owns the result.
- rsp_root  output  ROOT_W  floor(sqrt(x²+y²)).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-clean deassert):
  - state=IDLE.
  - rsp_valid=0, rsp_id=0, rsp_root=0, busy=0, req_ready=0.
  - RR pointer last_grant=1, so requester 0 wins first.
- FSM states: IDLE -> SQUARE -> ROOT -> DONE -> IDLE.
- IDLE:
  - req_ready is combinational from state, req_valid and last_grant only.
  - One valid requester gets req_ready.
  - Both valid: grant goes to the requester != last_grant.
  - Accept edge (req_valid[g] & req_ready[g]): latch x, y and id=g; set last_grant=g; go to SQUARE.
  - Requesters must hold operands stable while valid; behaviour is undefined otherwise.
- SQUARE (1 cycle): register sum = x*x + y*y at SUM_W bits, no truncation (max 2*255² = 130050); go to ROOT.
- ROOT (exactly ITER cycles): restoring digit-by-digit integer sqrt, one result bit per cycle, MSB first, 2 radicand bits consumed per cycle.
  - Iteration counter counts ITER-1 down to 0; the result is floor, never rounded.
  - After the last iteration: load rsp_root and rsp_id, set rsp_valid=1, go to DONE.
- Latency: rsp_valid rises on the clock edge exactly ITER+1 edges after the accept edge. For DATA_W=8 that is 10 edges.
- DONE:
  - rsp_valid, rsp_root and rsp_id are held stable until rsp_ready=1 at a clock edge.
  - On that edge: rsp_valid=0, go to IDLE.
  - No new accept on the handshake edge; the next accept is possible one cycle later. Minimum throughput is 1 result per ITER+3 cycles.
- req_ready=0 in every state except IDLE. Requests arriving while busy wait; they are not dropped.
- rsp_valid is only high in DONE.
- rsp_root holds its last value after handshake; it clears only on reset.
- Reset mid-operation (any state): immediate return to reset values. The in-flight request is discarded and no rsp_valid pulse is produced.
- A single requester asserting continuously is re-granted every transaction; RR only alternates under contention.

Decomposition:
- Package mag_sched_pkg:
  - state enum {IDLE, SQUARE, ROOT, DONE}.
  - localparams SUM_W, ROOT_W, ITER as functions of DATA_W.
  - NUM_REQ = 2.
- Sub-module isqrt_serial:
  - Ports: clk, rst_n, start, radicand[SUM_W], done, root[ROOT_W].
  - Implements the ROOT stage: the remainder/partial-root registers and the iteration counter.
- The scheduler owns arbitration, operand latch, square stage and response channel; it starts isqrt_serial on SQUARE->ROOT and advances on done.

Test Plan:
- Single request port 0, x=3, y=4, rsp_ready=1 -> rsp_valid high exactly 10 edges after accept; rsp_root=5, rsp_id=0; busy low the cycle after handshake.
- Corners: (0,0)->0; (255,255)->360; (255,0)->255; (1,1)->1; (12,5)->13. All floor values checked against a reference model over 2000 random pairs.
- Both req_valid high from reset, (3,4) on port 0 and (6,8) on port 1:
  - port 0 granted first, rsp 5, id 0; port 1 then granted, rsp 10, id 1.
  - Second simultaneous round grants port 0 again (alternation preserved).
- Backpressure: rsp_ready held 0 for 20 cycles after rsp_valid -> outputs stable, req_ready stays 0 and port 1 waits; release -> IDLE, port 1 accepted next cycle.
- Reset asserted during the 4th ROOT cycle of (200,150) -> outputs at reset values asynchronously and no rsp_valid pulse. After release, a request (8,15) returns 17 with normal latency, port 0 favoured.
- Port 0 only, valid continuously, 3 back-to-back requests -> each accepted one cycle after the previous handshake; every req_ready pulse is on port 0.

Source files
------------

// File: rtl/mag_sched_pkg.sv
// Shared widths, state encodings and width helpers for the magnitude request scheduler.
package mag_sched_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NUM_REQ    = 2;

  function automatic int unsigned sum_w_of(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

  function automatic int unsigned root_w_of(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned iter_of(input int unsigned dw);
    return dw + 1;
  endfunction

  localparam int unsigned SUM_W  = sum_w_of(DATA_W_DEF);
  localparam int unsigned ROOT_W = root_w_of(DATA_W_DEF);
  localparam int unsigned ITER   = iter_of(DATA_W_DEF);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SQUARE = 2'd1;
  localparam logic [ST_W-1:0] ST_ROOT   = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/isqrt_serial.sv
// Restoring bit-serial integer square root: one root bit per cycle, MSB first.
module isqrt_serial
  import mag_sched_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned SW     = sum_w_of(DATA_W),
  localparam int unsigned RW     = root_w_of(DATA_W),
  localparam int unsigned IT     = iter_of(DATA_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] radicand,
  output logic          done,
  output logic [RW-1:0] root
);

  localparam int unsigned RAD_W = 2 * IT;
  localparam int unsigned REM_W = RW + 3;
  localparam int unsigned CNT_W = $clog2(IT);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RAD_W-1:0] rad_q;
  logic [REM_W-1:0] rem_q;
  logic [RW-1:0]    root_q;

  logic [REM_W-1:0] rem_sh_c;
  logic [REM_W-1:0] trial_c;
  logic [REM_W-1:0] rem_d;
  logic [RW-1:0]    root_d;
  logic             fit_c;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rem_sh_c = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
    trial_c  = (REM_W'(root_q) << 2) | REM_W'(1);
    fit_c    = (rem_sh_c >= trial_c);
    rem_d    = fit_c ? (rem_sh_c - trial_c) : rem_sh_c;
    root_d   = (root_q << 1) | RW'(fit_c);
  end

  // The final step's root is presented the same cycle done is high.
  assign done = run_q && (cnt_q == '0);
  assign root = root_d;

  // Load radicand on start, then iterate IT times counting down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      cnt_q  <= CNT_W'(IT - 1);
      rad_q  <= RAD_W'(radicand);
      rem_q  <= '0;
      root_q <= '0;
    end else if (run_q) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_d;
      root_q <= root_d;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mag_req_scheduler.sv
// Round-robin front end sharing one floor(sqrt(x^2+y^2)) datapath between two requesters.
module mag_req_scheduler
  import mag_sched_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned SW     = sum_w_of(DATA_W),
  localparam int unsigned RW     = root_w_of(DATA_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [RW-1:0]             rsp_root,
  output logic                      busy
);

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic              last_q;
  logic              id_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;

  logic              grant_c;
  logic              acc_c;
  logic [DATA_W-1:0] x_c;
  logic [DATA_W-1:0] y_c;
  logic [SW-1:0]     sum_c;
  logic              sq_start_c;
  logic              sq_done;
  logic [RW-1:0]     sq_root;

  // Arbitration: under contention favour the requester not granted last.
  always_comb begin
    grant_c   = 1'b0;
    req_ready = '0;
    if (req_valid[0] && req_valid[1]) begin
      grant_c = ~last_q;
    end else begin
      grant_c = req_valid[1];
    end
    if (state_q == ST_IDLE && req_valid[grant_c]) begin
      req_ready[grant_c] = 1'b1;
    end
    acc_c = |req_ready;
    x_c   = grant_c ? req_x[2*DATA_W-1:DATA_W] : req_x[DATA_W-1:0];
    y_c   = grant_c ? req_y[2*DATA_W-1:DATA_W] : req_y[DATA_W-1:0];
  end

  // Full-width sum of squares; captured by the root unit as its radicand.
  always_comb begin
    sum_c      = SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);
    sq_start_c = (state_q == ST_SQUARE);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (acc_c)     state_d = ST_SQUARE;
      ST_SQUARE:                state_d = ST_ROOT;
      ST_ROOT:   if (sq_done)   state_d = ST_DONE;
      ST_DONE:   if (rsp_ready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, RR pointer and registered response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_root  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      if (acc_c) begin
        x_q    <= x_c;
        y_q    <= y_c;
        id_q   <= grant_c;
        last_q <= grant_c;
      end
      if (state_q == ST_ROOT && sq_done) begin
        rsp_valid <= 1'b1;
        rsp_root  <= sq_root;
        rsp_id    <= id_q;
      end else if (state_q == ST_DONE && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  isqrt_serial #(.DATA_W(DATA_W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sq_start_c),
    .radicand (sum_c),
    .done     (sq_done),
    .root     (sq_root)
  );

endmodule

// File: tb/tb_mag_req_scheduler.sv
// Self-checking bench: per-cycle transaction-level model plus directed literal checks.
module tb_mag_req_scheduler;

  localparam int unsigned LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [8:0]  rsp_root;
  logic        busy;

  always #5 clk = ~clk;

  mag_req_scheduler #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_root  (rsp_root),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt_ref(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // Transaction-level reference: idle/busy, edges since accept, pending result.
  bit         m_busy, m_valid, m_id, m_last, p_id;
  int         m_cnt, m_root, p_root, m_g, m_x, m_y;
  logic [1:0] m_er;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_root  = 0;
      m_last  = 1'b1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_root", rsp_root, 0);
      check("rst_rsp_id", rsp_id, 0);
    end else begin
      m_er = 2'b00;
      m_g  = -1;
      if (!m_busy) begin
        if (req_valid == 2'b11) m_g = m_last ? 0 : 1;
        else if (req_valid[0])  m_g = 0;
        else if (req_valid[1])  m_g = 1;
        if (m_g >= 0) m_er[m_g] = 1'b1;
      end
      check("req_ready", req_ready, m_er);
      check("rsp_valid", rsp_valid, m_valid);
      check("busy", busy, m_busy);
      check("rsp_root", rsp_root, m_root);
      if (m_valid) check("rsp_id", rsp_id, m_id);
      if (!m_busy) begin
        if (m_g >= 0) begin
          m_x    = int'(req_x[m_g*8 +: 8]);
          m_y    = int'(req_y[m_g*8 +: 8]);
          m_busy = 1'b1;
          m_cnt  = 0;
          m_last = m_g[0];
          p_id   = m_g[0];
          p_root = isqrt_ref(m_x * m_x + m_y * m_y);
        end
      end else if (!m_valid) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_valid = 1'b1;
          m_root  = p_root;
          m_id    = p_id;
        end
      end else if (rsp_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end
  end

  // Stimulus-side bookkeeping.
  int cyc;
  int hs_cyc;
  int acc_cyc[2];
  bit hold;
  bit prev_rv;
  int rq_id[$];
  int rq_root[$];
  int rq_lat[$];
  int gap_q[$];

  task automatic set_op(input int p, input int x, input int y);
    req_x[p*8 +: 8] = 8'(x);
    req_y[p*8 +: 8] = 8'(y);
  endtask

  // One clock: sample handshakes at negedge, advance, update inputs #1 after the edge.
  task automatic step();
    logic [1:0] acc;
    bit         hs;
    @(negedge clk);
    acc = req_valid & req_ready;
    hs  = rsp_valid & rsp_ready;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        acc_cyc[i] = cyc;
        gap_q.push_back(cyc - hs_cyc);
        if (!hold) req_valid[i] = 1'b0;
      end
    end
    if (hs) hs_cyc = cyc;
    if (rsp_valid && !prev_rv) begin
      rq_id.push_back(int'(rsp_id));
      rq_root.push_back(int'(rsp_root));
      rq_lat.push_back(cyc - acc_cyc[rsp_id]);
    end
    prev_rv = rsp_valid;
  endtask

  task automatic collect(input int n);
    rq_id.delete();
    rq_root.delete();
    rq_lat.delete();
    for (int k = 0; k < 300 && rq_id.size() < n; k++) step();
    if (rq_id.size() < n) check("rsp_timeout", rq_id.size(), n);
  endtask

  task automatic exp_rsp(input int k, input string name, input int id, input int root);
    if (rq_id.size() > k) begin
      check({name, "_id"}, rq_id[k], id);
      check({name, "_root"}, rq_root[k], root);
      check({name, "_lat"}, rq_lat[k], LAT);
    end
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    prev_rv = 1'b0;
    hs_cyc  = -100;
  endtask

  function automatic int rnd_op();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 255;
    return int'($urandom_range(0, 255));
  endfunction

  int cx[5] = '{0, 255, 255, 1, 12};
  int cy[5] = '{0, 255, 0, 1, 5};
  int cr[5] = '{0, 360, 255, 1, 13};

  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    hold      = 1'b0;
    cyc       = 0;
    acc_cyc   = '{0, 0};
    #2;
    do_reset();
    check("init_busy", busy, 0);

    // Single request, full latency and busy drop after handshake.
    set_op(0, 3, 4);
    req_valid = 2'b01;
    collect(1);
    exp_rsp(0, "single_3_4", 0, 5);
    step();
    check("busy_after_hs", busy, 0);

    // Corner operands.
    for (int i = 0; i < 5; i++) begin
      set_op(0, cx[i], cy[i]);
      req_valid = 2'b01;
      collect(1);
      exp_rsp(0, $sformatf("corner%0d", i), 0, cr[i]);
      step();
    end

    // Contention from reset: port 0 first, then port 1; second round repeats order.
    do_reset();
    set_op(0, 3, 4);
    set_op(1, 6, 8);
    req_valid = 2'b11;
    collect(2);
    exp_rsp(0, "rr1_a", 0, 5);
    exp_rsp(1, "rr1_b", 1, 10);
    req_valid = 2'b11;
    collect(2);
    exp_rsp(0, "rr2_a", 0, 5);
    exp_rsp(1, "rr2_b", 1, 10);
    step();

    // Backpressure: result held, port 1 waits, then accepted one cycle after release.
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    collect(1);
    exp_rsp(0, "bp_first", 0, 5);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_root", rsp_root, 5);
      check("bp_hold_id", rsp_id, 0);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_p1_ready", req_ready, 2);
    gap_q.delete();
    collect(1);
    exp_rsp(0, "bp_second", 1, 10);
    if (gap_q.size() > 0) check("bp_accept_gap", gap_q[0], 1);
    else check("bp_accept_seen", 0, 1);
    step();

    // Reset during the 4th ROOT cycle of (200,150).
    set_op(0, 200, 150);
    req_valid = 2'b01;
    step();
    check("mid_busy", busy, 1);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", rsp_valid, 0);
    check("async_busy", busy, 0);
    check("async_rsp_root", rsp_root, 0);
    check("async_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    prev_rv = 1'b0;
    rq_id.delete();
    repeat (15) step();
    check("no_pulse_after_rst", rq_id.size(), 0);
    set_op(0, 8, 15);
    set_op(1, 5, 12);
    req_valid = 2'b11;
    collect(2);
    exp_rsp(0, "post_rst_a", 0, 17);
    exp_rsp(1, "post_rst_b", 1, 13);
    step();

    // Port 0 continuously valid: three back-to-back grants.
    hold = 1'b1;
    set_op(0, 3, 4);
    req_valid = 2'b01;
    gap_q.delete();
    collect(3);
    hold      = 1'b0;
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) exp_rsp(k, $sformatf("b2b%0d", k), 0, 5);
    check("b2b_accepts", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap1", gap_q[1], 1);
      check("b2b_gap2", gap_q[2], 1);
    end
    step();

    // Randomized traffic, checked cycle-by-cycle by the model.
    rq_id.delete();
    rq_root.delete();
    rq_lat.delete();
    for (int k = 0; k < 40000 && rq_id.size() < 2000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, rnd_op(), rnd_op());
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    if (rq_id.size() < 2000) check("rand_timeout", rq_id.size(), 2000);

    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (15) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
